fetch_queue_stage: RTL

- Parametrised instruction fetch front-end: holds the PC and issues word requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses, buffers them with their PCs in a FQ_DEPTH-entry queue, and presents them to decode under stall control.
- Supports PC redirect from execute/branch logic, with flush and discard of stale in-flight responses.

---
 rtl/fetch_queue_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction fetch front-end: PC generation, credit-limited imem requests, in-order response queue, redirect flush.
// Define FETCH_BYPASS_EN for a 0-cycle response-to-decode path when the queue is empty.
module fetch_queue_stage #(
  parameter int                  ARCH_LEN  = 32,
  parameter int                  INST_LEN  = 32,
  parameter logic [ARCH_LEN-1:0] BOOT_ADDR = 32'h0000_1000,
  parameter int                  FQ_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [ARCH_LEN-1:0] redirect_pc,
  input  logic                stall_fet_in,
  output logic                inst_valid_out,
  output logic [INST_LEN-1:0] inst_out,
  output logic [ARCH_LEN-1:0] inst_pc_out
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic                started;
  logic [ARCH_LEN-1:0] fetch_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       q_count;
  logic [PW-1:0]       q_head;
  logic [PW-1:0]       q_tail;
  logic [PW-1:0]       ifl_rd;
  logic [PW-1:0]       ifl_wr;

  logic [INST_LEN-1:0] q_data [FQ_DEPTH];
  logic [ARCH_LEN-1:0] q_pc   [FQ_DEPTH];
  logic [ARCH_LEN-1:0] ifl_pc [FQ_DEPTH];

  logic [CW:0] in_use;
  logic        has_credit;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic        q_empty;
  logic        byp_hit;
  logic        byp_take;
  logic        q_push;
  logic        q_pop;

  // Requests in flight plus queued entries never exceed the queue size, so the queue cannot overflow.
  assign in_use     = {1'b0, outstanding} + {1'b0, q_count};
  assign has_credit = in_use < (CW + 1)'(FQ_DEPTH);

  assign imem_req_valid = started && has_credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_take && !redirect_valid && (drop_cnt == '0);
  assign q_empty  = (q_count == '0);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    byp_hit        = 1'b0;
    byp_take       = 1'b0;
    inst_valid_out = !q_empty && !redirect_valid;
    inst_out       = '0;
    inst_pc_out    = '0;
    if (!q_empty) begin
      inst_out    = q_data[q_head];
      inst_pc_out = q_pc[q_head];
    end
`ifdef FETCH_BYPASS_EN
    else begin
      byp_hit  = rsp_keep;
      byp_take = rsp_keep && !stall_fet_in;
      if (byp_hit) begin
        inst_valid_out = 1'b1;
        inst_out       = imem_rsp_data;
        inst_pc_out    = ifl_pc[ifl_rd];
      end
    end
`endif
  end

  assign q_push = rsp_keep && !byp_take;
  assign q_pop  = !q_empty && !redirect_valid && !stall_fet_in;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      fetch_pc    <= BOOT_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_count     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      ifl_rd      <= '0;
      ifl_wr      <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (req_fire) ifl_wr <= ifl_wr + PW'(1);
      if (rsp_take) ifl_rd <= ifl_rd + PW'(1);

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~ARCH_LEN'(3);
        // Everything still in flight after this cycle is stale, including nothing arriving now.
        drop_cnt <= outstanding - CW'(rsp_take);
        q_count  <= '0;
        q_head   <= '0;
        q_tail   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ARCH_LEN'(4);
        if (rsp_take && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (q_push) q_tail <= q_tail + PW'(1);
        if (q_pop)  q_head <= q_head + PW'(1);
        q_count <= q_count + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (req_fire) ifl_pc[ifl_wr] <= imem_req_addr;
    if (q_push) begin
      q_data[q_tail] <= imem_rsp_data;
      q_pc[q_tail]   <= ifl_pc[ifl_rd];
    end
  end

  a_rsp_has_credit : assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule
